climate_setpoint_ctrl: RTL and testbench
========================================

CLIMATE_SETPOINT_CTRL -- requirements
Module: climate_setpoint_ctrl

Interface
REQ-001 Parameter TW, default 8: width of temperature, humidity and setpoint buses.
REQ-002 Parameter TEMP_MIN, default 18: lowest legal setpoint.
REQ-003 Parameter TEMP_MAX, default 35: highest legal setpoint.
REQ-004 Parameter TEMP_RST, default 24: setpoint after reset; TEMP_MIN <= TEMP_RST <= TEMP_MAX.
REQ-005 Parameter STEP, default 1: setpoint increment/decrement per step event.
REQ-006 Parameter HOLD_CYC, default 50_000_000: held-button cycles before the first auto-repeat.
REQ-007 Parameter REPEAT_CYC, default 10_000_000: cycles between subsequent auto-repeats.
REQ-008 Parameter HYST, default 1: heat/cool hysteresis band in degrees.
REQ-009 clk  in  1  system clock, all state on rising edge.
REQ-010 reset  in  1  reset, asynchronous, active-high.
REQ-011 btn_up, btn_dn, btn_mode  in  1 each  debounced, clk-synchronous button levels.
REQ-012 mode  in  2  0 = IDLE (off), 1 = AUTO, 2 = MANUAL, 3 = reserved, treated as IDLE.
REQ-013 cur_temp, humidity  in  TW each  unsigned sensor values.
REQ-014 target_temp  out  TW  registered setpoint.
REQ-015 hvac_state  out  2  registered: 0 = OFF, 1 = HEAT, 2 = COOL.
REQ-016 heat_cool  out  1  registered, 1 exactly when hvac_state = COOL.
REQ-017 level  out  2  registered comfort/fan level, 0..3.
REQ-018 ultrasonic_mode  out  1  registered toggle flag.

Function
REQ-019 A rising edge of btn_up (btn_dn) with mode = MANUAL and the other button low SHALL apply one step on the next cycle.
REQ-020 While one button is held alone in MANUAL, a hold counter SHALL produce a further step HOLD_CYC cycles after the edge, then every REPEAT_CYC cycles.
REQ-021 Release, both buttons high, or mode != MANUAL SHALL clear the hold counter and suppress steps; setpoint retained.
REQ-022 Step arithmetic in TW+1 bits; result saturates at TEMP_MAX (up) or TEMP_MIN (down), never wraps.
REQ-023 Rising edge of btn_mode SHALL toggle ultrasonic_mode in every mode; a held button toggles once only.
REQ-024 HVAC FSM states OFF, HEAT, COOL; mode IDLE/reserved forces OFF on the next cycle.
REQ-025 OFF->COOL when cur_temp > target_temp+HYST; OFF->HEAT when cur_temp < target_temp-HYST; comparisons in TW+1 bits, no underflow.
REQ-026 COOL->OFF when cur_temp <= target_temp; HEAT->OFF when cur_temp >= target_temp; no direct HEAT<->COOL transition.
REQ-027 level SHALL be computed from cur_temp (and humidity, per REQ-032) and registered with one-cycle latency.
REQ-028 Temperature bands: 24..27 -> 0, 22..29 -> 1, 20..31 -> 2, else 3; humidity bands 40..60, 30..70, 20..80; level = the first band satisfied by all enabled inputs.

Reset
REQ-029 reset SHALL force target_temp = TEMP_RST, hvac_state = OFF, heat_cool = 0, level = 3, ultrasonic_mode = 0, and clear the hold counter and edge registers.
REQ-030 Reset asserted mid-hold SHALL abort the repeat; after release, a button still high SHALL NOT register as a new edge until it drops and rises again.

Configuration
REQ-031 Macro CLIMATE_HUMID_LEVEL_EN SHALL select the level source.
REQ-032 Defined: level uses temperature and humidity bands (REQ-028); undefined: temperature bands only, humidity input unused.

Structure
REQ-033 Shared package climate_pkg SHALL hold the mode encodings, the hvac_state encodings and the level band limit constants.
REQ-034 Sub-module btn_repeat (edge detect + hold/repeat counter, one instance per direction) SHALL produce single-cycle step pulses.

Verification (TW=8, HOLD_CYC=4, REPEAT_CYC=2, HYST=1, defaults otherwise)
REQ-035 After reset, target_temp = 24 and level = 3; one btn_up pulse in MANUAL -> 25 one cycle later.
REQ-036 btn_up held 10 cycles from target 24 -> steps at edge+1, +4, +6, +8, +10 -> 29.
REQ-037 From 34, hold btn_up -> 35 and stays 35; from 19, hold btn_dn -> 18 and stays 18; with STEP=3 from 33, up -> 35.
REQ-038 Target 24, cur_temp 26 -> COOL; cur 25 -> stays COOL; cur 24 -> OFF; cur 22 -> HEAT; switch mode to IDLE -> OFF next cycle.
REQ-039 cur_temp 25, humidity 75 -> level 2 with macro, 0 without; btn_mode held 20 cycles -> ultrasonic_mode toggles once.
REQ-040 Both buttons high, or btn_up in AUTO -> target unchanged; reset mid-hold -> 24, no step after release while button still high.

Source files
------------

// File: rtl/climate_pkg.sv
// Shared encodings and comfort-band limits for the climate setpoint controller.
// The level helper covers both builds; callers pass use_h = 0 when humidity is ignored.
package climate_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_MANUAL = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    HVAC_OFF  = 2'd0,
    HVAC_HEAT = 2'd1,
    HVAC_COOL = 2'd2
  } hvac_e;

  localparam logic [31:0] LVL0_T_LO = 32'd24;
  localparam logic [31:0] LVL0_T_HI = 32'd27;
  localparam logic [31:0] LVL1_T_LO = 32'd22;
  localparam logic [31:0] LVL1_T_HI = 32'd29;
  localparam logic [31:0] LVL2_T_LO = 32'd20;
  localparam logic [31:0] LVL2_T_HI = 32'd31;
  localparam logic [31:0] LVL0_H_LO = 32'd40;
  localparam logic [31:0] LVL0_H_HI = 32'd60;
  localparam logic [31:0] LVL1_H_LO = 32'd30;
  localparam logic [31:0] LVL1_H_HI = 32'd70;
  localparam logic [31:0] LVL2_H_LO = 32'd20;
  localparam logic [31:0] LVL2_H_HI = 32'd80;

  // Bands are nested, so testing from widest to narrowest leaves the tightest match.
  function automatic logic [1:0] level_of(input logic [31:0] t, input logic [31:0] h,
                                          input logic use_h);
    logic [1:0] lvl;
    lvl = 2'd3;
    if ((t >= LVL2_T_LO) && (t <= LVL2_T_HI) && (!use_h || ((h >= LVL2_H_LO) && (h <= LVL2_H_HI)))) begin
      lvl = 2'd2;
    end
    if ((t >= LVL1_T_LO) && (t <= LVL1_T_HI) && (!use_h || ((h >= LVL1_H_LO) && (h <= LVL1_H_HI)))) begin
      lvl = 2'd1;
    end
    if ((t >= LVL0_T_LO) && (t <= LVL0_T_HI) && (!use_h || ((h >= LVL0_H_LO) && (h <= LVL0_H_HI)))) begin
      lvl = 2'd0;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/climate_setpoint_ctrl_btn_repeat.sv
// Button edge detect plus hold/auto-repeat counter; emits registered one-cycle step pulses.
// en_i is high only while this button is pressed alone in MANUAL mode.
module btn_repeat #(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  input  logic en_i,
  output logic step_o
);

  localparam int CMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);

  logic          btn_q;
  logic          active_q;
  logic          rep_q;
  logic [CW-1:0] cnt_q;
  logic          step_q;
  logic [CW-1:0] last_s;

  assign last_s = rep_q ? REP_LAST : HOLD_LAST;
  assign step_o = step_q;

  // Previous level resets high so a button held through reset is not seen as a new press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q    <= 1'b1;
      active_q <= 1'b0;
      rep_q    <= 1'b0;
      cnt_q    <= '0;
      step_q   <= 1'b0;
    end else begin
      btn_q  <= btn_i;
      step_q <= 1'b0;
      if (!en_i) begin
        active_q <= 1'b0;
        rep_q    <= 1'b0;
        cnt_q    <= '0;
      end else if (!btn_q) begin
        active_q <= 1'b1;
        rep_q    <= 1'b0;
        cnt_q    <= CW'(1);
        step_q   <= 1'b1;
      end else if (active_q) begin
        if (cnt_q == last_s) begin
          step_q <= 1'b1;
          rep_q  <= 1'b1;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/climate_setpoint_ctrl.sv
// Thermostat setpoint, HVAC heat/cool FSM, comfort level and ultrasonic toggle.
// Build option: define CLIMATE_HUMID_LEVEL_EN to include humidity in the level bands.
module climate_setpoint_ctrl
  import climate_pkg::*;
#(
  parameter int TW         = 8,
  parameter int TEMP_MIN   = 18,
  parameter int TEMP_MAX   = 35,
  parameter int TEMP_RST   = 24,
  parameter int STEP       = 1,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int HYST       = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_up,
  input  logic          btn_dn,
  input  logic          btn_mode,
  input  logic [1:0]    mode,
  input  logic [TW-1:0] cur_temp,
  input  logic [TW-1:0] humidity,
  output logic [TW-1:0] target_temp,
  output logic [1:0]    hvac_state,
  output logic          heat_cool,
  output logic [1:0]    level,
  output logic          ultrasonic_mode
);

  localparam logic [TW:0]   MAX_W  = (TW+1)'(TEMP_MAX);
  localparam logic [TW:0]   MIN_W  = (TW+1)'(TEMP_MIN);
  localparam logic [TW:0]   STEP_W = (TW+1)'(STEP);
  localparam logic [TW:0]   HYST_W = (TW+1)'(HYST);
  localparam logic [TW-1:0] MAX_N  = TW'(TEMP_MAX);
  localparam logic [TW-1:0] MIN_N  = TW'(TEMP_MIN);
  localparam logic [TW-1:0] RST_N  = TW'(TEMP_RST);
  localparam logic [TW-1:0] STEP_N = TW'(STEP);

  logic          manual_s, off_mode_s;
  logic          en_up_s, en_dn_s, step_up_s, step_dn_s;
  logic [TW:0]   tgt_w_s, cur_w_s, sum_s;
  logic [TW-1:0] up_s, dn_s, target_d, target_q;
  logic [1:0]    level_s, level_q;
  hvac_e         hvac_q;
  logic          heat_cool_q, mode_btn_q, us_q;

  assign manual_s   = (mode == MODE_MANUAL);
  assign off_mode_s = (mode != MODE_AUTO) && (mode != MODE_MANUAL);
  assign en_up_s    = btn_up & ~btn_dn & manual_s;
  assign en_dn_s    = btn_dn & ~btn_up & manual_s;

  btn_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_rpt_up (
    .clk(clk), .reset(reset), .btn_i(btn_up), .en_i(en_up_s), .step_o(step_up_s)
  );

  btn_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_rpt_dn (
    .clk(clk), .reset(reset), .btn_i(btn_dn), .en_i(en_dn_s), .step_o(step_dn_s)
  );

  assign tgt_w_s = {1'b0, target_q};
  assign cur_w_s = {1'b0, cur_temp};
  assign sum_s   = tgt_w_s + STEP_W;

  // Saturating step arithmetic one bit wider than the bus so nothing wraps.
  always_comb begin
    up_s     = (sum_s > MAX_W) ? MAX_N : sum_s[TW-1:0];
    dn_s     = (tgt_w_s < (MIN_W + STEP_W)) ? MIN_N : (target_q - STEP_N);
    target_d = target_q;
    if (step_up_s) begin
      target_d = up_s;
    end else if (step_dn_s) begin
      target_d = dn_s;
    end else begin
      target_d = target_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q <= RST_N;
    end else begin
      target_q <= target_d;
    end
  end

  // HVAC state machine; heat_cool is registered alongside the state it mirrors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hvac_q      <= HVAC_OFF;
      heat_cool_q <= 1'b0;
    end else if (off_mode_s) begin
      hvac_q      <= HVAC_OFF;
      heat_cool_q <= 1'b0;
    end else begin
      case (hvac_q)
        HVAC_OFF: begin
          if (cur_w_s > (tgt_w_s + HYST_W)) begin
            hvac_q      <= HVAC_COOL;
            heat_cool_q <= 1'b1;
          end else if ((cur_w_s + HYST_W) < tgt_w_s) begin
            hvac_q      <= HVAC_HEAT;
            heat_cool_q <= 1'b0;
          end else begin
            hvac_q      <= HVAC_OFF;
            heat_cool_q <= 1'b0;
          end
        end
        HVAC_COOL: begin
          if (cur_w_s <= tgt_w_s) begin
            hvac_q      <= HVAC_OFF;
            heat_cool_q <= 1'b0;
          end else begin
            hvac_q      <= HVAC_COOL;
            heat_cool_q <= 1'b1;
          end
        end
        HVAC_HEAT: begin
          hvac_q      <= (cur_w_s >= tgt_w_s) ? HVAC_OFF : HVAC_HEAT;
          heat_cool_q <= 1'b0;
        end
        default: begin
          hvac_q      <= HVAC_OFF;
          heat_cool_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
`ifdef CLIMATE_HUMID_LEVEL_EN
    level_s = level_of(32'(cur_temp), 32'(humidity), 1'b1);
`else
    level_s = level_of(32'(cur_temp), 32'(humidity), 1'b0);
`endif
  end

  // Level register plus ultrasonic toggle; the mode-button history resets high like the steppers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q    <= 2'd3;
      mode_btn_q <= 1'b1;
      us_q       <= 1'b0;
    end else begin
      level_q    <= level_s;
      mode_btn_q <= btn_mode;
      us_q       <= us_q ^ (btn_mode & ~mode_btn_q);
    end
  end

  assign target_temp     = target_q;
  assign hvac_state      = hvac_q;
  assign heat_cool       = heat_cool_q;
  assign level           = level_q;
  assign ultrasonic_mode = us_q;

endmodule

// File: tb/tb_climate_setpoint_ctrl.sv
// Directed plus randomized bench for climate_setpoint_ctrl against a cycle-level behavioural model.
module tb_climate_setpoint_ctrl;

  localparam int HOLD = 4;
  localparam int REP  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_dn = 1'b0, btn_mode = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] cur_temp = 8'd25, humidity = 8'd50;
  logic [7:0] target_temp, target_temp3;
  logic [1:0] hvac_state, hvac_state3, level, level3;
  logic       heat_cool, heat_cool3, ultrasonic_mode, ultrasonic_mode3;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_tgt, m_tgt3, m_hvac, m_lvl, m_us;
  bit m_prev_up, m_prev_dn, m_prev_md;
  bit m_val_up, m_val_dn, m_pend_up, m_pend_dn;
  int m_n_up, m_n_dn;

  always #5 clk = ~clk;

  climate_setpoint_ctrl #(.TW(8), .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .HYST(1)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn), .btn_mode(btn_mode),
    .mode(mode), .cur_temp(cur_temp), .humidity(humidity), .target_temp(target_temp),
    .hvac_state(hvac_state), .heat_cool(heat_cool), .level(level),
    .ultrasonic_mode(ultrasonic_mode)
  );

  climate_setpoint_ctrl #(.TW(8), .STEP(3), .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .HYST(1)) dut3 (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn), .btn_mode(btn_mode),
    .mode(mode), .cur_temp(cur_temp), .humidity(humidity), .target_temp(target_temp3),
    .hvac_state(hvac_state3), .heat_cool(heat_cool3), .level(level3),
    .ultrasonic_mode(ultrasonic_mode3)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 35) return 35;
    if (v < 18) return 18;
    return v;
  endfunction

  // Step due at hold index n: the press itself, then HOLD after it, then every REP.
  function automatic bit step_due(input int n);
    if (n == 0) return 1'b1;
    if (n >= HOLD - 1 && ((n - (HOLD - 1)) % REP) == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int band_level(input int t, input int h);
    bit hum_en;
`ifdef CLIMATE_HUMID_LEVEL_EN
    hum_en = 1'b1;
`else
    hum_en = 1'b0;
`endif
    if (t >= 24 && t <= 27 && (!hum_en || (h >= 40 && h <= 60))) return 0;
    if (t >= 22 && t <= 29 && (!hum_en || (h >= 30 && h <= 70))) return 1;
    if (t >= 20 && t <= 31 && (!hum_en || (h >= 20 && h <= 80))) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_tgt = 24; m_tgt3 = 24; m_hvac = 0; m_lvl = 3; m_us = 0;
    m_prev_up = 1'b1; m_prev_dn = 1'b1; m_prev_md = 1'b1;
    m_val_up = 1'b0; m_val_dn = 1'b0; m_pend_up = 1'b0; m_pend_dn = 1'b0;
    m_n_up = 0; m_n_dn = 0;
  endtask

  task automatic model_step();
    int  old_tgt, ct;
    bit  man;
    if (reset) begin
      model_reset();
      return;
    end
    old_tgt = m_tgt;
    ct      = int'(cur_temp);
    man     = (mode == 2'd2);
    if (m_pend_up) begin
      m_tgt = sat(m_tgt + 1); m_tgt3 = sat(m_tgt3 + 3);
    end else if (m_pend_dn) begin
      m_tgt = sat(m_tgt - 1); m_tgt3 = sat(m_tgt3 - 3);
    end
    if (btn_up && !btn_dn && man) begin
      if (!m_prev_up) begin m_val_up = 1'b1; m_n_up = 0; end
      else if (m_val_up) m_n_up++;
      m_pend_up = m_val_up && step_due(m_n_up);
    end else begin
      m_val_up = 1'b0; m_pend_up = 1'b0;
    end
    if (btn_dn && !btn_up && man) begin
      if (!m_prev_dn) begin m_val_dn = 1'b1; m_n_dn = 0; end
      else if (m_val_dn) m_n_dn++;
      m_pend_dn = m_val_dn && step_due(m_n_dn);
    end else begin
      m_val_dn = 1'b0; m_pend_dn = 1'b0;
    end
    if (mode == 2'd0 || mode == 2'd3) m_hvac = 0;
    else if (m_hvac == 0) m_hvac = (ct > old_tgt + 1) ? 2 : ((ct < old_tgt - 1) ? 1 : 0);
    else if (m_hvac == 2) m_hvac = (ct <= old_tgt) ? 0 : 2;
    else m_hvac = (ct >= old_tgt) ? 0 : 1;
    m_lvl = band_level(ct, int'(humidity));
    if (btn_mode && !m_prev_md) m_us = 1 - m_us;
    m_prev_up = btn_up; m_prev_dn = btn_dn; m_prev_md = btn_mode;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("target", int'(target_temp), m_tgt);
    check_eq("target_step3", int'(target_temp3), m_tgt3);
    check_eq("hvac", int'(hvac_state), m_hvac);
    check_eq("heat_cool", int'(heat_cool), (m_hvac == 2) ? 1 : 0);
    check_eq("level", int'(level), m_lvl);
    check_eq("ultrasonic", int'(ultrasonic_mode), m_us);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    btn_up = 1'b0; btn_dn = 1'b0; btn_mode = 1'b0;
    reset = 1'b1;
    tick();
    check_eq("rst_target", int'(target_temp), 24);
    check_eq("rst_level", int'(level), 3);
    check_eq("rst_hvac", int'(hvac_state), 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic press(input bit up);
    if (up) btn_up = 1'b1; else btn_dn = 1'b1;
    tick();
    btn_up = 1'b0; btn_dn = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    // Single press, then held repeat cadence
    do_reset();
    mode = 2'd2;
    press(1'b1);
    check_eq("single_up", int'(target_temp), 25);
    do_reset();
    btn_up = 1'b1; ticks(10);
    btn_up = 1'b0; tick();
    check_eq("hold_up_10", int'(target_temp), 29);

    // Saturation at both ends, and STEP=3 clamp
    do_reset();
    for (int i = 0; i < 3; i++) press(1'b1);
    check_eq("step3_33", int'(target_temp3), 33);
    press(1'b1);
    check_eq("step3_sat", int'(target_temp3), 35);
    for (int i = 0; i < 6; i++) press(1'b1);
    check_eq("at_34", int'(target_temp), 34);
    btn_up = 1'b1; ticks(8); btn_up = 1'b0; tick();
    check_eq("sat_max", int'(target_temp), 35);
    for (int i = 0; i < 16; i++) press(1'b0);
    check_eq("at_19", int'(target_temp), 19);
    btn_dn = 1'b1; ticks(8); btn_dn = 1'b0; tick();
    check_eq("sat_min", int'(target_temp), 18);

    // HVAC sequence
    do_reset();
    mode = 2'd1;
    cur_temp = 8'd26; tick(); check_eq("hvac_cool", int'(hvac_state), 2);
    check_eq("hc_cool", int'(heat_cool), 1);
    cur_temp = 8'd25; tick(); check_eq("hvac_stay_cool", int'(hvac_state), 2);
    cur_temp = 8'd24; tick(); check_eq("hvac_off", int'(hvac_state), 0);
    cur_temp = 8'd22; tick(); check_eq("hvac_heat", int'(hvac_state), 1);
    mode = 2'd0; tick(); check_eq("hvac_idle_off", int'(hvac_state), 0);

    // Level with humidity, ultrasonic hold
    cur_temp = 8'd25; humidity = 8'd75; tick();
`ifdef CLIMATE_HUMID_LEVEL_EN
    check_eq("level_humid", int'(level), 2);
`else
    check_eq("level_humid", int'(level), 0);
`endif
    btn_mode = 1'b1; ticks(20); btn_mode = 1'b0; tick();
    check_eq("us_once", int'(ultrasonic_mode), 1);

    // Suppression: both buttons, AUTO mode, reset mid-hold
    do_reset();
    mode = 2'd1; btn_up = 1'b1; ticks(4);
    check_eq("auto_no_step", int'(target_temp), 24);
    mode = 2'd2; btn_dn = 1'b1; ticks(5);
    btn_up = 1'b0; btn_dn = 1'b0; tick();
    check_eq("both_no_step", int'(target_temp), 24);
    btn_up = 1'b1; ticks(5);
    check_eq("mid_hold", int'(target_temp), 26);
    reset = 1'b1; tick(); reset = 1'b0;
    ticks(10);
    check_eq("rst_mid_hold", int'(target_temp), 24);
    btn_up = 1'b0; tick();

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 11) == 0) btn_dn = ~btn_dn;
      if ($urandom_range(0, 9) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 39) == 0) mode = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      if ($urandom_range(0, 4) == 0) cur_temp = 8'($urandom_range(10, 40));
      if ($urandom_range(0, 4) == 0) humidity = 8'($urandom_range(0, 100));
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
